// File: rtl/icache_responder_if.sv
// Fetch-side and instruction-memory-side signals of the instruction cache responder.
// slave is the cache's view; master is the fetch/memory side that drives it.
interface icache_responder_if;
  logic [31:0]  pc_i;
  logic         invalidate_i;
  logic [31:0]  instr_o;
  logic         hit_o;
  logic         stall_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ack_i;
  logic [127:0] mem_data_i;

  modport slave (
    input  pc_i,
    input  invalidate_i,
    output instr_o,
    output hit_o,
    output stall_o,
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_data_i
  );

  modport master (
    output pc_i,
    output invalidate_i,
    input  instr_o,
    input  hit_o,
    input  stall_o,
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_data_i
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache serving fetch combinationally on a hit.
// On a miss it stalls fetch and refills the whole line over a req/ack handshake.
module icache_responder #(
  parameter int unsigned NUM_LINES  = 4,
  parameter int unsigned LINE_BYTES = 16
) (
  input logic               clk_i,
  input logic               rsn_i,
  icache_responder_if.slave bus
);

  localparam int unsigned OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 32 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REFILL
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [127:0]           data_q [NUM_LINES];

  logic [IDX_W-1:0]       lk_idx;
  logic [TAG_W-1:0]       lk_tag;
  logic [1:0]             lk_word;
  logic [IDX_W-1:0]       fill_idx;
  logic                   fill_we;
  logic                   hit;
  logic                   unused_pc_bits;

  assign lk_idx         = bus.pc_i[OFF_W +: IDX_W];
  assign lk_tag         = bus.pc_i[31 -: TAG_W];
  assign lk_word        = bus.pc_i[3:2];
  assign fill_idx       = addr_q[OFF_W +: IDX_W];
  assign unused_pc_bits = ^bus.pc_i[1:0];

  assign hit = (state_q == IDLE) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign bus.hit_o      = hit;
  assign bus.stall_o    = ~hit;
  assign bus.instr_o    = hit ? data_q[lk_idx][32*lk_word +: 32] : '0;
  assign bus.mem_req_o  = (state_q == REQ);
  assign bus.mem_addr_o = addr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    fill_we = 1'b0;

    // Invalidate clears first so a fill completing in the same cycle still lands valid.
    if (bus.invalidate_i) begin
      valid_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (!hit && !bus.invalidate_i) begin
          addr_d  = {bus.pc_i[31:OFF_W], {OFF_W{1'b0}}};
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.mem_ack_i) begin
          fill_we           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = REFILL;
        end
      end
      REFILL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  // Tag/data arrays carry no reset; valid bits alone gate their use.
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      data_q[fill_idx] <= bus.mem_data_i;
      tag_q[fill_idx]  <= addr_q[31 -: TAG_W];
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: cold miss, hits, eviction, redirect, invalidate, async reset.
module tb_icache_responder;

  logic clk_i;
  logic rsn_i;
  int   errors;
  int   checks;

  icache_responder_if bus ();

  icache_responder #(
    .NUM_LINES (4),
    .LINE_BYTES(16)
  ) dut (
    .clk_i(clk_i),
    .rsn_i(rsn_i),
    .bus  (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [127:0] line_of(input logic [15:0] hi);
    return {hi, 16'd3, hi, 16'd2, hi, 16'd1, hi, 16'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // Called while in REQ: check the held request, ack once, pass the REFILL bubble, land in IDLE.
  task automatic do_fill(input string tag, input logic [31:0] exp_addr, input logic [127:0] d);
    chk({tag, "_req"}, 32'(bus.mem_req_o), 32'd1);
    chk({tag, "_addr"}, bus.mem_addr_o, exp_addr);
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = d;
    tick();
    bus.mem_ack_i  = 1'b0;
    settle();
    chk({tag, "_refill_stall"}, 32'(bus.stall_o), 32'd1);
    chk({tag, "_refill_req"}, 32'(bus.mem_req_o), 32'd0);
    tick();
    settle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rsn_i            = 1'b0;
    bus.pc_i         = 32'h0000_1000;
    bus.invalidate_i = 1'b0;
    bus.mem_ack_i    = 1'b0;
    bus.mem_data_i   = '0;

    // Reset state
    #3;
    chk("rst_hit", 32'(bus.hit_o), 32'd0);
    chk("rst_stall", 32'(bus.stall_o), 32'd1);
    chk("rst_instr", bus.instr_o, 32'd0);
    chk("rst_req", 32'(bus.mem_req_o), 32'd0);
    chk("rst_addr", bus.mem_addr_o, 32'd0);

    // Cold miss, ack three cycles after the request rises
    tick();
    rsn_i = 1'b1;
    settle();
    chk("cold_miss_hit", 32'(bus.hit_o), 32'd0);
    chk("cold_miss_stall", 32'(bus.stall_o), 32'd1);
    chk("cold_miss_req", 32'(bus.mem_req_o), 32'd0);
    tick();
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("cold_wait_req", 32'(bus.mem_req_o), 32'd1);
      chk("cold_wait_addr", bus.mem_addr_o, 32'h0000_1000);
      chk("cold_wait_stall", 32'(bus.stall_o), 32'd1);
      tick();
      settle();
    end
    do_fill("cold", 32'h0000_1000, line_of(16'hAAAA));
    chk("cold_hit", 32'(bus.hit_o), 32'd1);
    chk("cold_stall", 32'(bus.stall_o), 32'd0);
    chk("cold_instr", bus.instr_o, 32'hAAAA_0000);

    // Same-line hits
    for (int w = 1; w < 4; w++) begin
      tick();
      bus.pc_i = 32'h0000_1000 + 32'(4 * w);
      settle();
      chk("line_hit", 32'(bus.hit_o), 32'd1);
      chk("line_stall", 32'(bus.stall_o), 32'd0);
      chk("line_req", 32'(bus.mem_req_o), 32'd0);
      chk("line_instr", bus.instr_o, 32'hAAAA_0000 + 32'(w));
    end

    // Conflict eviction on index 0
    bus.pc_i = 32'h0000_1040;
    settle();
    chk("conf_miss", 32'(bus.hit_o), 32'd0);
    chk("conf_instr0", bus.instr_o, 32'd0);
    tick();
    settle();
    do_fill("conf", 32'h0000_1040, line_of(16'hBBBB));
    chk("conf_hit_instr", bus.instr_o, 32'hBBBB_0000);
    bus.pc_i = 32'h0000_1000;
    settle();
    chk("evicted_miss", 32'(bus.hit_o), 32'd0);
    tick();
    settle();
    do_fill("refetch", 32'h0000_1000, line_of(16'hAAAA));
    chk("refetch_hit", 32'(bus.hit_o), 32'd1);

    // Redirect during fill
    bus.pc_i = 32'h0000_1010;
    settle();
    chk("redir_miss", 32'(bus.hit_o), 32'd0);
    tick();
    settle();
    bus.pc_i = 32'h0000_2000;
    settle();
    chk("redir_addr_held", bus.mem_addr_o, 32'h0000_1010);
    tick();
    settle();
    do_fill("redir", 32'h0000_1010, line_of(16'hCCCC));
    chk("redir_new_miss", 32'(bus.hit_o), 32'd0);
    tick();
    settle();
    do_fill("redir2", 32'h0000_2000, line_of(16'hDDDD));
    chk("redir2_instr", bus.instr_o, 32'hDDDD_0000);
    bus.pc_i = 32'h0000_1018;
    settle();
    chk("redir_installed_hit", 32'(bus.hit_o), 32'd1);
    chk("redir_installed_instr", bus.instr_o, 32'hCCCC_0002);

    // Invalidate with a miss in IDLE launches no request
    tick();
    bus.pc_i         = 32'h0000_3000;
    bus.invalidate_i = 1'b1;
    settle();
    chk("prio_miss", 32'(bus.hit_o), 32'd0);
    tick();
    bus.invalidate_i = 1'b0;
    settle();
    chk("prio_no_req", 32'(bus.mem_req_o), 32'd0);
    bus.pc_i = 32'h0000_1010;
    settle();
    chk("prio_cleared_miss", 32'(bus.hit_o), 32'd0);
    tick();
    settle();
    do_fill("prio", 32'h0000_1010, line_of(16'hCCCC));
    chk("prio_refill_instr", bus.instr_o, 32'hCCCC_0000);

    // Invalidate pulse with 0x1000 resident
    bus.pc_i = 32'h0000_1000;
    settle();
    tick();
    settle();
    do_fill("inv_prep", 32'h0000_1000, line_of(16'hAAAA));
    chk("inv_prep_hit", 32'(bus.hit_o), 32'd1);
    bus.invalidate_i = 1'b1;
    settle();
    chk("inv_same_cycle_hit", 32'(bus.hit_o), 32'd1);
    tick();
    bus.invalidate_i = 1'b0;
    settle();
    chk("inv_miss", 32'(bus.hit_o), 32'd0);
    tick();
    settle();
    chk("inv_req", 32'(bus.mem_req_o), 32'd1);
    chk("inv_addr", bus.mem_addr_o, 32'h0000_1000);

    // Async reset mid-fill, no clock edge in between
    rsn_i = 1'b0;
    settle();
    chk("arst_req", 32'(bus.mem_req_o), 32'd0);
    chk("arst_addr", bus.mem_addr_o, 32'd0);
    chk("arst_stall", 32'(bus.stall_o), 32'd1);
    chk("arst_instr", bus.instr_o, 32'd0);
    tick();
    rsn_i          = 1'b1;
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = line_of(16'hEEEE);
    settle();
    chk("late_ack_miss", 32'(bus.hit_o), 32'd0);
    chk("late_ack_req", 32'(bus.mem_req_o), 32'd0);
    tick();
    bus.mem_ack_i = 1'b0;
    settle();
    chk("late_ack_new_req", 32'(bus.mem_req_o), 32'd1);
    chk("late_ack_new_addr", bus.mem_addr_o, 32'h0000_1000);

    // Invalidate coinciding with the ack: filled line still lands valid
    bus.mem_ack_i    = 1'b1;
    bus.mem_data_i   = line_of(16'hAAAA);
    bus.invalidate_i = 1'b1;
    tick();
    bus.mem_ack_i    = 1'b0;
    bus.invalidate_i = 1'b0;
    settle();
    chk("inv_fill_refill_hit", 32'(bus.hit_o), 32'd0);
    tick();
    settle();
    chk("inv_fill_hit", 32'(bus.hit_o), 32'd1);
    chk("inv_fill_instr", bus.instr_o, 32'hAAAA_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
